// File: rtl/table_inserter_if.sv
// Request and shared-memory bus of the table inserter.
// Control side (master) raises start_i with key/value; the inserter (slave) drives the byte-wide memory port.
`ifndef QUAD_BUS
`define QUAD_BUS 63:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif

interface table_inserter_if;
    logic               start_i;
    logic [`QUAD_BUS]   key_i;
    logic [`DATA_BUS]   val_i;
    logic               mem_ce_o;
    logic               mem_we_o;
    logic [`ADDR_BUS]   mem_addr_o;
    logic [3:0]         mem_width_o;
    logic [`DATA_BUS]   mem_data_o;
    logic [`DATA_BUS]   mem_data_i;
    logic               ready_o;
    logic [`ADDR_BUS]   entry_addr_o;
    logic               collision_o;

    modport master (
        output start_i, key_i, val_i, mem_data_i,
        input  mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
        input  ready_o, entry_addr_o, collision_o
    );

    modport slave (
        input  start_i, key_i, val_i, mem_data_i,
        output mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
        output ready_o, entry_addr_o, collision_o
    );
endinterface

// File: rtl/table_inserter.sv
// Exact-match table inserter: hashes a key and writes key then value bytes into the entry slot.
// Optional read-before-write collision refusal is enabled by defining INSERTER_COLLISION_CHK_EN.
`ifndef QUAD_BUS
`define QUAD_BUS 63:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif

module table_hash (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key,
    output logic        ready,
    output logic [7:0]  hash_val
);
    // XOR fold of the eight key bytes; ready pulses one cycle after start is seen
    always_ff @(posedge clk) begin
        if (rst) begin
            ready    <= 1'b0;
            hash_val <= 8'h00;
        end else begin
            ready    <= start & ~ready;
            hash_val <= key[63:56] ^ key[55:48] ^ key[47:40] ^ key[39:32]
                      ^ key[31:24] ^ key[23:16] ^ key[15:8]  ^ key[7:0];
        end
    end
endmodule

module table_inserter #(
    parameter int KEY_LEN    = 4,
    parameter int VAL_LEN    = 4,
    parameter int ENTRY_LEN  = 16,
    parameter int START_ADDR = 128
) (
    input  logic            clk,
    input  logic            rst,
    table_inserter_if.slave bus
);
    typedef enum logic [2:0] {
        FREE      = 3'd0,
        HASH      = 3'd1,
        CHECK     = 3'd2,
        WRITE_KEY = 3'd3,
        WRITE_VAL = 3'd4,
        DONE      = 3'd5
    } state_t;

    // Unused key bytes are zeroed so the hash agrees with the lookup side
    localparam logic [63:0] KEY_MASK = ~(64'hFFFF_FFFF_FFFF_FFFF >> (8 * KEY_LEN));
    localparam logic [3:0]  KEY_LAST = 4'(KEY_LEN - 1);
    localparam logic [3:0]  VAL_LAST = 4'(VAL_LEN - 1);

    function automatic logic [7:0] key_byte(input logic [63:0] k, input logic [3:0] j);
        logic [63:0] s;
        s = k << (32'd8 * 32'(j));
        return s[63:56];
    endfunction

    function automatic logic [7:0] val_byte(input logic [31:0] v, input logic [3:0] j);
        logic [31:0] s;
        s = v >> (32'd8 * (32'(VAL_LEN) - 32'd1 - 32'(j)));
        return s[7:0];
    endfunction

    state_t           state_r;
    logic [63:0]      key_r;
    logic [`DATA_BUS] val_r;
    logic [`ADDR_BUS] base_r;
    logic [3:0]       cnt_r;
    logic             hash_start_r;
    logic             ce_r;
    logic             we_r;
    logic [`ADDR_BUS] addr_r;
    logic [7:0]       data_r;
    logic             ready_r;
    logic [`ADDR_BUS] entry_r;
    logic             hash_ready_s;
    logic [7:0]       hash_val_s;
    logic [`ADDR_BUS] base_calc_s;

    table_hash u_hash (
        .clk      (clk),
        .rst      (rst),
        .start    (hash_start_r),
        .key      (key_r),
        .ready    (hash_ready_s),
        .hash_val (hash_val_s)
    );

    assign base_calc_s = 32'(START_ADDR) + {24'h000000, hash_val_s} * 32'(ENTRY_LEN);

`ifdef INSERTER_COLLISION_CHK_EN
    logic collision_r;
    logic zero_r;
    logic match_r;
    logic zero_next_s;
    logic match_next_s;

    // Running "slot empty" / "slot holds this key" verdicts including the byte read this cycle
    always_comb begin
        zero_next_s  = 1'b0;
        match_next_s = 1'b0;
        if (state_r == CHECK) begin
            zero_next_s  = zero_r  & (bus.mem_data_i[7:0] == 8'h00);
            match_next_s = match_r & (bus.mem_data_i[7:0] == key_byte(key_r, cnt_r));
        end else begin
            zero_next_s  = zero_r;
            match_next_s = match_r;
        end
    end

    assign bus.collision_o = collision_r;
`else
    assign bus.collision_o = 1'b0;
`endif

    assign bus.mem_ce_o     = ce_r;
    assign bus.mem_we_o     = we_r;
    assign bus.mem_addr_o   = addr_r;
    assign bus.mem_width_o  = 4'd1;
    assign bus.mem_data_o   = {24'h000000, data_r};
    assign bus.ready_o      = ready_r;
    assign bus.entry_addr_o = entry_r;

    // Insert sequencer; addr/data always show the byte that the next edge writes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= FREE;
            key_r        <= 64'h0;
            val_r        <= 32'h0;
            base_r       <= 32'h0;
            cnt_r        <= 4'd0;
            hash_start_r <= 1'b0;
            ce_r         <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= 32'h0;
            data_r       <= 8'h00;
            ready_r      <= 1'b0;
            entry_r      <= 32'h0;
`ifdef INSERTER_COLLISION_CHK_EN
            collision_r  <= 1'b0;
            zero_r       <= 1'b0;
            match_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                FREE: begin
                    ce_r <= 1'b0;
                    we_r <= 1'b0;
                    if (bus.start_i) begin
                        key_r        <= bus.key_i & KEY_MASK;
                        val_r        <= bus.val_i;
                        ready_r      <= 1'b0;
                        entry_r      <= 32'h0;
                        hash_start_r <= 1'b1;
`ifdef INSERTER_COLLISION_CHK_EN
                        collision_r  <= 1'b0;
`endif
                        state_r      <= HASH;
                    end
                end
                HASH: begin
                    if (hash_ready_s) begin
                        hash_start_r <= 1'b0;
                        base_r       <= base_calc_s;
                        addr_r       <= base_calc_s;
                        cnt_r        <= 4'd0;
                        ce_r         <= 1'b1;
`ifdef INSERTER_COLLISION_CHK_EN
                        we_r         <= 1'b0;
                        zero_r       <= 1'b1;
                        match_r      <= 1'b1;
                        state_r      <= CHECK;
`else
                        we_r         <= 1'b1;
                        data_r       <= key_byte(key_r, 4'd0);
                        state_r      <= WRITE_KEY;
`endif
                    end
                end
`ifdef INSERTER_COLLISION_CHK_EN
                CHECK: begin
                    if (cnt_r == KEY_LAST) begin
                        if (zero_next_s || match_next_s) begin
                            we_r    <= 1'b1;
                            addr_r  <= base_r;
                            data_r  <= key_byte(key_r, 4'd0);
                            cnt_r   <= 4'd0;
                            state_r <= WRITE_KEY;
                        end else begin
                            ce_r        <= 1'b0;
                            we_r        <= 1'b0;
                            ready_r     <= 1'b1;
                            collision_r <= 1'b1;
                            entry_r     <= 32'h0;
                            state_r     <= DONE;
                        end
                    end else begin
                        cnt_r   <= cnt_r + 4'd1;
                        addr_r  <= addr_r + 32'd1;
                        zero_r  <= zero_next_s;
                        match_r <= match_next_s;
                    end
                end
`endif
                WRITE_KEY: begin
                    addr_r <= addr_r + 32'd1;
                    if (cnt_r == KEY_LAST) begin
                        cnt_r   <= 4'd0;
                        data_r  <= val_byte(val_r, 4'd0);
                        state_r <= WRITE_VAL;
                    end else begin
                        cnt_r   <= cnt_r + 4'd1;
                        data_r  <= key_byte(key_r, cnt_r + 4'd1);
                    end
                end
                WRITE_VAL: begin
                    if (cnt_r == VAL_LAST) begin
                        ce_r    <= 1'b0;
                        we_r    <= 1'b0;
                        ready_r <= 1'b1;
                        entry_r <= base_r;
                        state_r <= DONE;
                    end else begin
                        cnt_r   <= cnt_r + 4'd1;
                        addr_r  <= addr_r + 32'd1;
                        data_r  <= val_byte(val_r, cnt_r + 4'd1);
                    end
                end
                DONE: begin
                    ce_r <= 1'b0;
                    we_r <= 1'b0;
                    if (!bus.start_i) begin
                        ready_r <= 1'b0;
                        state_r <= FREE;
                    end
                end
                default: begin
                    ce_r         <= 1'b0;
                    we_r         <= 1'b0;
                    hash_start_r <= 1'b0;
                    state_r      <= FREE;
                end
            endcase
        end
    end
endmodule
